button_debouncer_multi: RTL and testbench
=========================================

Name: button_debouncer_multi

Overview:
- N-channel, parametrised debouncer for board push-buttons and switches.
- Each channel is synchronised, debounced with a programmable stability window, and edge-decoded.
- Also provides long-press detection and auto-repeat pulses.
- Sits between the board pins and the control FSM that starts and steps the systolic array, so that FSM sees clean, single-cycle events.

Parameters:
- NUM_CH, 5, number of independent button channels.
- SYNC_STAGES, 2, synchroniser flops per channel (legal range 2..4).
- DEBOUNCE_CYCLES, 65536, consecutive cycles a new level must persist before it is accepted (must be ≥1).
- HOLD_CYCLES, 50000000, cycles a pressed level must persist before the channel counts as held (long press).
- REPEAT_CYCLES, 10000000, period of auto-repeat pulses while held (must be ≥1).
- REPEAT_EN, 1, 1 enables btn_held and btn_repeat; 0 ties both low.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- btn_in  in  NUM_CH  raw asynchronous button levels, 1 = pressed.
- btn_out  out  NUM_CH  debounced stable level per channel.
- btn_rise  out  NUM_CH  one-cycle pulse when btn_out goes 0→1.
- btn_fall  out  NUM_CH  one-cycle pulse when btn_out goes 1→0.
- btn_held  out  NUM_CH  level; 1 while pressed for at least HOLD_CYCLES.
- btn_repeat  out  NUM_CH  one-cycle auto-repeat pulse while held.

Behaviour:
- Reset:
  - Asynchronous reset clears all synchroniser flops, counters, btn_out, btn_rise, btn_fall, btn_held and btn_repeat to 0.
  - Reset mid-debounce or mid-hold abandons the count; no pulse is emitted on reset entry or on reset release.
- Synchroniser: a SYNC_STAGES-deep flop chain per channel; s = output of the last stage.
- Debounce counter (per channel, width clog2(DEBOUNCE_CYCLES+1)):
  - If s == btn_out: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: btn_out <= s and counter <= 0.
  - Else: counter <= counter+1.
  - Any glitch back to the btn_out level restarts the count from 0.
  - Latency from a clean btn_in step to the btn_out change is SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Edge outputs:
  - btn_rise and btn_fall are registered and asserted in the same cycle btn_out changes; high for exactly 1 cycle.
  - They are never both high, and each is high at most once per btn_out transition.
- Hold/repeat state machine (per channel, REPEAT_EN=1):
  - IDLE: btn_out=0. Hold counter = 0. On btn_out rising → PRESS.
  - PRESS: hold counter increments each cycle. When it reaches HOLD_CYCLES-1 → HELD. On that transition, btn_held <= 1, btn_repeat pulses once, and the repeat counter is cleared.
  - HELD: repeat counter increments; when it reaches REPEAT_CYCLES-1 it pulses btn_repeat for 1 cycle and wraps to 0.
  - Any state: btn_out falling → IDLE. On that transition, btn_held <= 0, all counters clear, and btn_repeat is not asserted in that cycle.
  - The first repeat pulse coincides with btn_held rising, HOLD_CYCLES cycles after btn_rise; later pulses come every REPEAT_CYCLES cycles.
- Counter widths: each counter is sized to its own parameter; saturation is not required because every count terminates at its compare value.
- Independence: channels are fully independent. Simultaneous events on different channels produce pulses in the same cycle, unaffected by each other.
- Parameter boundaries:
  - DEBOUNCE_CYCLES=1: a new level is accepted after it is seen for 1 cycle (latency SYNC_STAGES+1).
  - REPEAT_CYCLES=1: btn_repeat is high every cycle while held.
  - REPEAT_EN=0: the hold/repeat logic is not generated.

Test Plan:
- Reset/idle: NUM_CH=2, DEBOUNCE_CYCLES=4. Assert rst at an arbitrary time with btn_in=2'b11 → all outputs 0 immediately (before the next clk edge). Release rst → no btn_rise or btn_fall pulse in the first cycle; btn_out=2'b11 exactly 2+4 cycles after release.
- Clean press/release: DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
  - btn_in[0] 0→1 at cycle 0 → btn_out[0]=1 and btn_rise[0]=1 at cycle 6 only.
  - Release at cycle 20 → btn_fall[0]=1 at cycle 26 only.
  - btn_out[1] and all other channel-1 outputs stay 0 throughout.
- Bounce rejection: DEBOUNCE_CYCLES=4. Toggle btn_in[0] 1,0,1,0 every 3 cycles, then hold 1 → zero pulses during the bounce; a single btn_rise[0] 6 cycles after the final stable edge.
- Long press and repeat: HOLD_CYCLES=10, REPEAT_CYCLES=3.
  - Hold the button → btn_held and btn_repeat both 1 at 10 cycles after btn_rise; btn_repeat pulses again at +13, +16, +19.
  - Release → btn_held=0 in the cycle btn_fall pulses, and no btn_repeat in that cycle.
- Simultaneous channels / REPEAT_EN=0:
  - NUM_CH=3: press all three in the same cycle → three btn_rise bits asserted in the same cycle.
  - Rebuild with REPEAT_EN=0: a long hold yields btn_held=0 and btn_repeat=0 forever.
- Reset mid-operation: assert rst during PRESS, 5 cycles after btn_rise, with btn_in still 1 → btn_out=0 immediately and the count is abandoned. After release, a fresh btn_rise occurs SYNC_STAGES+DEBOUNCE_CYCLES cycles later; btn_held does not assert until a full HOLD_CYCLES after that btn_rise.

Source files
------------

// File: rtl/button_debouncer_multi.sv
// Multi-channel push-button debouncer: synchroniser, stability filter and
// edge decode per channel, plus optional long-press and auto-repeat.
module button_debouncer_multi #(
    parameter int NUM_CH          = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] btn_in,
    output logic [NUM_CH-1:0] btn_out,
    output logic [NUM_CH-1:0] btn_rise,
    output logic [NUM_CH-1:0] btn_fall,
    output logic [NUM_CH-1:0] btn_held,
    output logic [NUM_CH-1:0] btn_repeat
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS, HELD} hstate_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [DW-1:0]          db_cnt;
        logic                   s;
        logic                   out_q;
        logic                   rise_q;
        logic                   fall_q;
        logic                   accept;
        logic                   rise_now;
        logic                   fall_now;
        logic                   held_w;
        logic                   rep_w;

        assign s        = sync_q[SYNC_STAGES-1];
        assign accept   = (s != out_q) && (db_cnt == DB_LAST);
        assign rise_now = accept && s;
        assign fall_now = accept && !s;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= '0;
                db_cnt <= '0;
                out_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[i]};
                rise_q <= rise_now;
                fall_q <= fall_now;
                if (s == out_q) begin
                    db_cnt <= '0;
                end else if (accept) begin
                    out_q  <= s;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
            end
        end

        if (REPEAT_EN) begin : g_hold
            localparam int HW = $clog2(HOLD_CYCLES + 1);
            localparam int RW = $clog2(REPEAT_CYCLES + 1);
            localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
            localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

            hstate_t       state_q;
            hstate_t       state_d;
            logic [HW-1:0] hold_cnt;
            logic [RW-1:0] rep_cnt;
            logic          rep_q;
            logic          rep_d;
            logic          hold_done;
            logic          rep_done;

            assign hold_done = hold_cnt == HOLD_LAST;
            assign rep_done  = rep_cnt == REP_LAST;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q  <= IDLE;
                    hold_cnt <= '0;
                    rep_cnt  <= '0;
                    rep_q    <= 1'b0;
                end else begin
                    state_q <= state_d;
                    rep_q   <= rep_d;
                    if (state_q == PRESS && state_d == PRESS)
                        hold_cnt <= hold_cnt + HW'(1);
                    else
                        hold_cnt <= '0;
                    if (state_q == HELD && state_d == HELD)
                        rep_cnt <= rep_done ? '0 : rep_cnt + RW'(1);
                    else
                        rep_cnt <= '0;
                end
            end

            // A debounced release wins over every other transition.
            always_comb begin
                state_d = state_q;
                unique case (state_q)
                    IDLE:    if (rise_now) state_d = PRESS;
                    PRESS:   if (hold_done) state_d = HELD;
                    HELD:    state_d = HELD;
                    default: state_d = IDLE;
                endcase
                if (fall_now) state_d = IDLE;
            end

            always_comb begin
                rep_d = 1'b0;
                if (state_d == HELD)
                    rep_d = (state_q == PRESS) || (state_q == HELD && rep_done);
            end

            assign held_w = state_q == HELD;
            assign rep_w  = rep_q;
        end else begin : g_nohold
            assign held_w = 1'b0;
            assign rep_w  = 1'b0;
        end

        assign btn_out[i]    = out_q;
        assign btn_rise[i]   = rise_q;
        assign btn_fall[i]   = fall_q;
        assign btn_held[i]   = held_w;
        assign btn_repeat[i] = rep_w;
    end

endmodule

// File: tb/tb_button_debouncer_multi.sv
// Bench for button_debouncer_multi: scoreboard of timed events on the
// main instance plus cycle checks on REPEAT_EN=0 and boundary instances.
module tb_button_debouncer_multi;

    typedef struct packed {
        logic [31:0] t;
        logic [1:0]  k;
        logic [2:0]  v;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] btn_a = '0, btn_b = '0, btn_c = '0;
    logic [2:0] out_a, rise_a, fall_a, held_a, rep_a;
    logic [2:0] out_b, rise_b, fall_b, held_b, rep_b;
    logic [2:0] out_c, rise_c, fall_c, held_c, rep_c;
    logic [2:0] held_prev = '0;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    string tag = "init";
    ev_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_debouncer_multi #(
        .NUM_CH(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .REPEAT_EN(1'b1)
    ) u_a (
        .clk(clk), .rst(rst), .btn_in(btn_a), .btn_out(out_a),
        .btn_rise(rise_a), .btn_fall(fall_a), .btn_held(held_a),
        .btn_repeat(rep_a)
    );

    button_debouncer_multi #(
        .NUM_CH(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .REPEAT_EN(1'b0)
    ) u_b (
        .clk(clk), .rst(rst), .btn_in(btn_b), .btn_out(out_b),
        .btn_rise(rise_b), .btn_fall(fall_b), .btn_held(held_b),
        .btn_repeat(rep_b)
    );

    button_debouncer_multi #(
        .NUM_CH(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1),
        .HOLD_CYCLES(4), .REPEAT_CYCLES(1), .REPEAT_EN(1'b1)
    ) u_c (
        .clk(clk), .rst(rst), .btn_in(btn_c), .btn_out(out_c),
        .btn_rise(rise_c), .btn_fall(fall_c), .btn_held(held_c),
        .btn_repeat(rep_c)
    );

    // kinds: 0 rise, 1 fall, 2 held change (v = new held), 3 repeat
    function automatic void expect_ev(int t, int k, logic [2:0] v);
        ev_t e;
        e.t = t;
        e.k = 2'(k);
        e.v = v;
        exp_q.push_back(e);
    endfunction

    task automatic tick(input int n);
        logic [2:0] v [4];
        logic hit;
        ev_t got, want;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            v[0] = rise_a;
            v[1] = fall_a;
            v[2] = held_a;
            v[3] = rep_a;
            for (int k = 0; k < 4; k++) begin
                hit = (k == 2) ? (held_a != held_prev) : (v[k] != 3'b0);
                if (!rst && hit) begin
                    got.t = cyc;
                    got.k = 2'(k);
                    got.v = v[k];
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL %s extra got=t%0d/k%0d/%b want=none",
                                 tag, got.t, got.k, got.v);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            bad++;
                            $display("FAIL %s event got=t%0d/k%0d/%b want=t%0d/k%0d/%b",
                                     tag, got.t, got.k, got.v, want.t, want.k, want.v);
                        end
                    end
                end
            end
            held_prev = held_a;
        end
    endtask

    task automatic drain_check();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s pending got=%0d want=0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        int c;
        tag = "reset";
        total++;
        if ({out_a, rise_a, fall_a, held_a, rep_a} !== 15'b0) begin
            bad++;
            $display("FAIL reset_hold got=%h want=0",
                     {out_a, rise_a, fall_a, held_a, rep_a});
        end
        btn_a = 3'b011;
        rst = 1'b0;
        c = cyc;
        expect_ev(c + 6, 0, 3'b011);
        tick(10);
        total++;
        if (out_a !== 3'b011) begin
            bad++;
            $display("FAIL reset_pre got=%b want=011", out_a);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({out_a, rise_a, fall_a, held_a, rep_a} !== 15'b0) begin
            bad++;
            $display("FAIL reset_async got=%h want=0",
                     {out_a, rise_a, fall_a, held_a, rep_a});
        end
        tick(2);
        rst = 1'b0;
        c = cyc;
        expect_ev(c + 6, 0, 3'b011);
        tick(5);
        total++;
        if (out_a !== 3'b000) begin
            bad++;
            $display("FAIL reset_early got=%b want=000", out_a);
        end
        tick(1);
        total++;
        if (out_a !== 3'b011) begin
            bad++;
            $display("FAIL reset_lat got=%b want=011", out_a);
        end
        btn_a = 3'b000;
        expect_ev(c + 12, 1, 3'b011);
        tick(8);
        drain_check();
    endtask

    task automatic test_press();
        int c;
        tag = "press";
        c = cyc;
        btn_a = 3'b001;
        expect_ev(c + 6, 0, 3'b001);
        tick(8);
        total++;
        if (out_a !== 3'b001) begin
            bad++;
            $display("FAIL press_out got=%b want=001", out_a);
        end
        btn_a = 3'b000;
        expect_ev(c + 14, 1, 3'b001);
        tick(10);
        total++;
        if (out_a !== 3'b000) begin
            bad++;
            $display("FAIL press_rel got=%b want=000", out_a);
        end
        drain_check();
    endtask

    task automatic test_bounce();
        int c;
        tag = "bounce";
        c = cyc;
        for (int i = 0; i < 4; i++) begin
            btn_a[0] = (i % 2 == 0);
            tick(3);
        end
        btn_a = 3'b001;
        expect_ev(c + 18, 0, 3'b001);
        tick(8);
        btn_a = 3'b000;
        expect_ev(c + 26, 1, 3'b001);
        tick(10);
        drain_check();
    endtask

    task automatic test_simultaneous();
        int c;
        tag = "simul";
        c = cyc;
        btn_a = 3'b111;
        expect_ev(c + 6, 0, 3'b111);
        tick(8);
        btn_a = 3'b000;
        expect_ev(c + 14, 1, 3'b111);
        tick(10);
        drain_check();
    endtask

    task automatic test_long_press();
        int c;
        tag = "long";
        c = cyc;
        btn_a = 3'b100;
        expect_ev(c + 6, 0, 3'b100);
        expect_ev(c + 16, 2, 3'b100);
        for (int r = 16; r <= 34; r += 3) expect_ev(c + r, 3, 3'b100);
        expect_ev(c + 36, 1, 3'b100);
        expect_ev(c + 36, 2, 3'b000);
        tick(30);
        btn_a = 3'b000;
        tick(10);
        drain_check();
    endtask

    task automatic test_reset_mid();
        int c;
        int r;
        tag = "rstmid";
        c = cyc;
        btn_a = 3'b001;
        expect_ev(c + 6, 0, 3'b001);
        tick(11);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({out_a, held_a, rep_a} !== 9'b0) begin
            bad++;
            $display("FAIL rstmid_async got=%h want=0", {out_a, held_a, rep_a});
        end
        tick(2);
        rst = 1'b0;
        r = cyc;
        expect_ev(r + 6, 0, 3'b001);
        expect_ev(r + 16, 2, 3'b001);
        for (int k = 16; k <= 25; k += 3) expect_ev(r + k, 3, 3'b001);
        expect_ev(r + 26, 1, 3'b001);
        expect_ev(r + 26, 2, 3'b000);
        tick(20);
        btn_a = 3'b000;
        tick(10);
        drain_check();
    endtask

    task automatic test_no_repeat();
        tag = "norep";
        btn_b = 3'b111;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            total++;
            if ({held_b, rep_b} !== 6'b0) begin
                bad++;
                $display("FAIL norep_c%0d got=%b want=000000", i, {held_b, rep_b});
            end
            if (i == 6) begin
                total++;
                if ({out_b, rise_b} !== 6'b111111) begin
                    bad++;
                    $display("FAIL norep_rise got=%b want=111111", {out_b, rise_b});
                end
            end
        end
        btn_b = 3'b000;
        tick(8);
        total++;
        if (out_b !== 3'b000) begin
            bad++;
            $display("FAIL norep_rel got=%b want=000", out_b);
        end
    endtask

    task automatic test_boundary();
        logic [14:0] want;
        tag = "bound";
        btn_c = 3'b001;
        for (int i = 1; i <= 16; i++) begin
            tick(1);
            want = '0;
            want[12] = (i >= 3 && i < 15);
            want[9]  = (i == 3);
            want[6]  = (i == 15);
            want[3]  = (i >= 7 && i < 15);
            want[0]  = (i >= 7 && i < 15);
            total++;
            if ({out_c, rise_c, fall_c, held_c, rep_c} !== want) begin
                bad++;
                $display("FAIL bound_c%0d got=%b want=%b", i,
                         {out_c, rise_c, fall_c, held_c, rep_c}, want);
            end
            if (i == 12) btn_c = 3'b000;
        end
    endtask

    initial begin
        tick(3);
        test_reset();
        test_press();
        test_bounce();
        test_simultaneous();
        test_long_press();
        test_reset_mid();
        test_no_repeat();
        test_boundary();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
